// File: rtl/matmul_seq_param_if.sv
// Start/busy/done handshake and operand/result buses for matmul_seq_param.
// The master side drives operands and start; the slave side returns C.
interface matmul_seq_param_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 8
);
    logic                  start;
    logic [N*N*DW-1:0]     A;
    logic [N*N*DW-1:0]     B;
    logic [N*N*OW-1:0]     C;
    logic                  busy;
    logic                  done;

    modport master (
        output start, A, B,
        input  C, busy, done
    );

    modport slave (
        input  start, A, B,
        output C, busy, done
    );
endinterface

// File: rtl/matmul_seq_param.sv
// Sequential signed NxN matrix multiplier, one MAC per clock.
// Define MATMUL_SAT_EN to saturate write-back instead of wrapping.
module matmul_seq_param #(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int OW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
) (
    input logic               Clock,
    input logic               reset,
    matmul_seq_param_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX =
        ACC_W'({1'b0, {(OW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0] a_m [N][N];
    logic signed [DW-1:0] b_m [N][N];
    logic [OW-1:0]        res_m [N][N];
    logic [N*N*OW-1:0]    c_q;
    logic [N*N*OW-1:0]    c_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] ax;
    logic signed [ACC_W-1:0] bx;
    logic [OW-1:0]           red;

    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [IW-1:0] k;

    logic capture;
    logic mac_en;
    logic last_k;
    logic last_elem;

    assign last_k    = (k == LAST);
    assign last_elem = last_k && (i == LAST) && (j == LAST);

    assign bus.busy = (state == MAC);
    assign bus.done = (state == DONE);
    assign bus.C    = c_q;

    // State register
    always_ff @(posedge Clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; start is honoured only when not computing
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        mac_en    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_elem)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One full-precision MAC step and its write-back reduction
    always_comb begin
        ax      = ACC_W'(a_m[i][k]);
        bx      = ACC_W'(b_m[k][j]);
        acc_nxt = acc + ax * bx;
`ifdef MATMUL_SAT_EN
        if (acc_nxt > SMAX)
            red = SMAX[OW-1:0];
        else if (acc_nxt < SMIN)
            red = SMIN[OW-1:0];
        else
            red = acc_nxt[OW-1:0];
`else
        red = acc_nxt[OW-1:0];
`endif
    end

    // Full result image with the element being written this cycle
    always_comb begin
        c_nxt = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (IW'(r) == i && IW'(c) == j)
                    c_nxt[(r*N+c)*OW +: OW] = red;
                else
                    c_nxt[(r*N+c)*OW +: OW] = res_m[r][c];
            end
        end
    end

    // Operand capture, index walk, accumulation and result update
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c]   <= '0;
                    b_m[r][c]   <= '0;
                    res_m[r][c] <= '0;
                end
            end
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
            c_q <= '0;
        end else if (capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c] <= bus.A[(r*N+c)*DW +: DW];
                    b_m[r][c] <= bus.B[(r*N+c)*DW +: DW];
                end
            end
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
        end else if (mac_en) begin
            if (last_k) begin
                res_m[i][j] <= red;
                acc         <= '0;
                k           <= '0;
                if (j == LAST) begin
                    j <= '0;
                    i <= (i == LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
                if (last_elem)
                    c_q <= c_nxt;
            end else begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matmul_seq_param.sv
// Bench for matmul_seq_param: N=3/8-bit and N=4/16-bit-out instances.
// A cycle-count + matrix-arithmetic model is compared every cycle.
module tb_matmul_seq_param;
    logic clk;
    logic rst;

    int vec;
    int errs;

    matmul_seq_param_if #(.N(3), .DW(8), .OW(8))  b3 ();
    matmul_seq_param_if #(.N(4), .DW(8), .OW(16)) b4 ();

    matmul_seq_param #(.N(3), .DW(8), .OW(8)) u3 (
        .Clock (clk),
        .reset (rst),
        .bus   (b3)
    );

    matmul_seq_param #(.N(4), .DW(8), .OW(16)) u4 (
        .Clock (clk),
        .reset (rst),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference product: full-precision sum, then reduce to ow bits
    function automatic logic [255:0] mm(input logic [127:0] a,
                                        input logic [127:0] b,
                                        input int n,
                                        input int ow);
        logic [255:0] res;
        longint s;
        longint hi;
        longint lo;
        res = '0;
        hi  = (longint'(1) << (ow-1)) - 1;
        lo  = -hi - 1;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int q = 0; q < n; q++)
                    s += longint'($signed(a[(r*n+q)*8 +: 8])) *
                         longint'($signed(b[(q*n+c)*8 +: 8]));
`ifdef MATMUL_SAT_EN
                if (s > hi) s = hi;
                if (s < lo) s = lo;
`else
                if (hi < lo) s = 0;
`endif
                for (int t = 0; t < ow; t++)
                    res[(r*n+c)*ow+t] = s[t];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd();
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    logic [255:0] m3_c, m4_c;
    logic [71:0]  m3_a, m3_b;
    logic [127:0] m4_a, m4_b;
    logic         m3_busy, m3_done, m4_busy, m4_done;
    int           m3_cnt, m4_cnt;

    // Model, N=3: capture, 27 edges of work, then result + done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m3_busy <= 1'b0;
            m3_done <= 1'b0;
            m3_c    <= '0;
            m3_cnt  <= 0;
        end else if (m3_busy) begin
            m3_cnt <= m3_cnt + 1;
            if (m3_cnt == 26) begin
                m3_c    <= mm({56'd0, m3_a}, {56'd0, m3_b}, 3, 8);
                m3_busy <= 1'b0;
                m3_done <= 1'b1;
            end
        end else if (b3.start) begin
            m3_a    <= b3.A;
            m3_b    <= b3.B;
            m3_busy <= 1'b1;
            m3_done <= 1'b0;
            m3_cnt  <= 0;
        end
    end

    // Model, N=4: capture, 64 edges of work, then result + done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4_busy <= 1'b0;
            m4_done <= 1'b0;
            m4_c    <= '0;
            m4_cnt  <= 0;
        end else if (m4_busy) begin
            m4_cnt <= m4_cnt + 1;
            if (m4_cnt == 63) begin
                m4_c    <= mm(m4_a, m4_b, 4, 16);
                m4_busy <= 1'b0;
                m4_done <= 1'b1;
            end
        end else if (b4.start) begin
            m4_a    <= b4.A;
            m4_b    <= b4.B;
            m4_busy <= 1'b1;
            m4_done <= 1'b0;
            m4_cnt  <= 0;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("c3", {184'd0, b3.C}, m3_c);
        chk("busy3", {255'd0, b3.busy}, {255'd0, m3_busy});
        chk("done3", {255'd0, b3.done}, {255'd0, m3_done});
        chk("excl3", {255'd0, b3.busy & b3.done}, '0);
        chk("c4", b4.C, m4_c);
        chk("busy4", {255'd0, b4.busy}, {255'd0, m4_busy});
        chk("done4", {255'd0, b4.done}, {255'd0, m4_done});
        chk("excl4", {255'd0, b4.busy & b4.done}, '0);
    end

    task automatic pulse3(input logic [71:0] a, input logic [71:0] b);
        @(negedge clk);
        #1;
        b3.A     = a;
        b3.B     = b;
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        b3.start = 1'b0;
    endtask

    task automatic pulse4(input logic [127:0] a, input logic [127:0] b);
        @(negedge clk);
        #1;
        b4.A     = a;
        b4.B     = b;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
    endtask

    task automatic waitd(input bit four, input int lat0, output int lat);
        int lim;
        lim = four ? 80 : 40;
        lat = lat0;
        while (!(four ? b4.done : b3.done) && lat < lim) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    logic [71:0]  a3, bb3, a3b, bb3b;
    logic [127:0] a4, bb4;
    int           lat;

    initial begin
        vec      = 0;
        errs     = 0;
        rst      = 1'b1;
        b3.start = 1'b0;
        b3.A     = '0;
        b3.B     = '0;
        b4.start = 1'b0;
        b4.A     = '0;
        b4.B     = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_c", {184'd0, b3.C}, '0);
        chk("rst_bd", {254'd0, b3.busy, b3.done}, '0);
        rst = 1'b0;

        // Identity x 1..9 gives B back
        pulse3(72'h01_00_00_00_01_00_00_00_01,
               72'h09_08_07_06_05_04_03_02_01);
        waitd(1'b0, 0, lat);
        chk("lat_id", 256'(lat), 256'd27);
        chk("c_id", {184'd0, b3.C}, {184'd0, 72'h09_08_07_06_05_04_03_02_01});
        chk("busy_id", {255'd0, b3.busy}, '0);

        // All ones: each element is 3
        pulse3({9{8'h01}}, {9{8'h01}});
        waitd(1'b0, 0, lat);
        chk("lat_one", 256'(lat), 256'd27);
        chk("c_one", {184'd0, b3.C}, {184'd0, {9{8'h03}}});

        // All -128: sum 49152 wraps to 0 or clamps to 127
        pulse3({9{8'h80}}, {9{8'h80}});
        waitd(1'b0, 0, lat);
`ifdef MATMUL_SAT_EN
        chk("c_neg", {184'd0, b3.C}, {184'd0, {9{8'h7F}}});
`else
        chk("c_neg", {184'd0, b3.C}, '0);
`endif

        // Random operands
        repeat (3) begin
            a3  = rnd()[71:0];
            bb3 = rnd()[71:0];
            pulse3(a3, bb3);
            waitd(1'b0, 0, lat);
            chk("lat_rnd", 256'(lat), 256'd27);
            chk("c_rnd", {184'd0, b3.C}, mm({56'd0, a3}, {56'd0, bb3}, 3, 8));
        end

        // New operands and start mid-run are ignored
        a3  = rnd()[71:0];
        bb3 = rnd()[71:0];
        pulse3(a3, bb3);
        repeat (9) @(posedge clk);
        #1;
        b3.A     = rnd()[71:0];
        b3.B     = rnd()[71:0];
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        b3.start = 1'b0;
        waitd(1'b0, 10, lat);
        chk("lat_mid", 256'(lat), 256'd27);
        chk("c_mid", {184'd0, b3.C}, mm({56'd0, a3}, {56'd0, bb3}, 3, 8));

        // Reset partway through aborts immediately
        pulse3(rnd()[71:0], rnd()[71:0]);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ab_c", {184'd0, b3.C}, '0);
        chk("ab_bd", {254'd0, b3.busy, b3.done}, '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        a3  = rnd()[71:0];
        bb3 = rnd()[71:0];
        pulse3(a3, bb3);
        waitd(1'b0, 0, lat);
        chk("lat_ab", 256'(lat), 256'd27);
        chk("c_ab", {184'd0, b3.C}, mm({56'd0, a3}, {56'd0, bb3}, 3, 8));

        // start held high: back-to-back runs 28 edges apart
        a3   = rnd()[71:0];
        bb3  = rnd()[71:0];
        a3b  = rnd()[71:0];
        bb3b = rnd()[71:0];
        @(negedge clk);
        #1;
        b3.A     = a3;
        b3.B     = bb3;
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        waitd(1'b0, 0, lat);
        chk("lat_h1", 256'(lat), 256'd27);
        chk("c_h1", {184'd0, b3.C}, mm({56'd0, a3}, {56'd0, bb3}, 3, 8));
        b3.A = a3b;
        b3.B = bb3b;
        @(posedge clk);
        #1;
        chk("h_pulse", {254'd0, b3.busy, b3.done}, 256'd2);
        waitd(1'b0, 0, lat);
        b3.start = 1'b0;
        chk("lat_h2", 256'(lat + 1), 256'd28);
        chk("c_h2", {184'd0, b3.C}, mm({56'd0, a3b}, {56'd0, bb3b}, 3, 8));
        @(posedge clk);
        #1;
        chk("h_stop", {254'd0, b3.busy, b3.done}, 256'd1);

        // N=4, 16-bit output, random signed operands
        repeat (3) begin
            a4  = rnd();
            bb4 = rnd();
            pulse4(a4, bb4);
            waitd(1'b1, 0, lat);
            chk("lat4", 256'(lat), 256'd64);
            chk("c4_run", b4.C, mm(a4, bb4, 4, 16));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
